// File: rtl/ht_ltf_pkg.sv
// Shared definitions for the HT-LTF sequencer: sizes, P_HTLTF sign table,
// symbol-count decode and FSM state encoding.
package ht_ltf_pkg;

  localparam int N_SC = 64;

  // Bit {row, col} set means P_HTLTF[row][col] == -1.
  // Rows: [+ - + +], [+ + - +], [+ + + -], [- + + +]
  localparam logic [15:0] P_HTLTF_NEG = 16'h1842;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index of the final symbol: 1 LTF -> 0, 2 LTF -> 1, 4 LTF -> 3.
  function automatic logic [1:0] last_sym_idx(input logic [1:0] sel);
    case (sel)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic p_htltf_neg(input logic [1:0] row, input logic [1:0] col);
    return P_HTLTF_NEG[{row, col}];
  endfunction

endpackage

// File: rtl/iq_sign_sat.sv
// Conditional negation of a packed {I, Q} sample, each half saturated so the
// most negative value maps to the most positive instead of wrapping.
module iq_sign_sat #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] data_i,
  input  logic          sgn_i,
  output logic [DW-1:0] data_o
);

  localparam int HW = DW / 2;

  function automatic logic [HW-1:0] neg_sat(input logic [HW-1:0] x);
    if (x == {1'b1, {(HW-1){1'b0}}}) begin
      return {1'b0, {(HW-1){1'b1}}};
    end
    return ~x + HW'(1);
  endfunction

  assign data_o = sgn_i ? {neg_sat(data_i[DW-1:HW]), neg_sat(data_i[HW-1:0])} : data_i;

endmodule

// File: rtl/ht_ltf_seq_ctrl.sv
// Streams the external HT-LTF coefficient ROM into the IFFT input, one
// 64-subcarrier symbol per HT-LTF, applying the P_HTLTF sign of the stream.
module ht_ltf_seq_ctrl
  import ht_ltf_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic [1:0]    num_ltf_sel,
  input  logic [1:0]    ss_idx,
  input  logic          abort,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_sym_idx,
  output logic          out_last_sc,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [5:0]    sc_cnt_q, sc_cnt_d;
  logic [1:0]    sym_cnt_q, sym_cnt_d;
  logic [1:0]    last_sym_q, last_sym_d;
  logic [1:0]    ss_q, ss_d;
  logic          loaded_all_q, loaded_all_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    out_sym_q, out_sym_d;
  logic          out_last_sc_q, out_last_sc_d;
  logic          out_last_q, out_last_d;

  logic [DW-1:0] signed_sample;
  logic          sc_last;
  logic          final_sample;
  logic          handshake;
  logic          load;

  iq_sign_sat #(.DW(DW)) u_sign (
    .data_i (rom_data),
    .sgn_i  (p_htltf_neg(ss_q, sym_cnt_q)),
    .data_o (signed_sample)
  );

  assign sc_last      = (sc_cnt_q == 6'(N_SC - 1));
  assign final_sample = sc_last && (sym_cnt_q == last_sym_q);
  assign handshake    = out_valid_q && out_ready;
  assign load         = (state_q == RUN) && !loaded_all_q && (!out_valid_q || out_ready);

  // A handshake and a refill can share a cycle; the refill wins for out_valid.
  always_comb begin
    state_d       = state_q;
    sc_cnt_d      = sc_cnt_q;
    sym_cnt_d     = sym_cnt_q;
    last_sym_d    = last_sym_q;
    ss_d          = ss_q;
    loaded_all_d  = loaded_all_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_sym_d     = out_sym_q;
    out_last_sc_d = out_last_sc_q;
    out_last_d    = out_last_q;

    if (enable) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d      = RUN;
            last_sym_d   = last_sym_idx(num_ltf_sel);
            ss_d         = ss_idx;
            sc_cnt_d     = '0;
            sym_cnt_d    = '0;
            loaded_all_d = 1'b0;
          end
        end
        RUN: begin
          if (handshake) begin
            out_valid_d   = 1'b0;
            out_last_sc_d = 1'b0;
            out_last_d    = 1'b0;
            if (out_last_q) state_d = DONE;
          end
          if (load) begin
            out_data_d    = signed_sample;
            out_valid_d   = 1'b1;
            out_sym_d     = sym_cnt_q;
            out_last_sc_d = sc_last;
            out_last_d    = final_sample;
            sc_cnt_d      = sc_cnt_q + 6'd1;
            if (final_sample) begin
              sym_cnt_d    = '0;
              loaded_all_d = 1'b1;
            end else if (sc_last) begin
              sym_cnt_d = sym_cnt_q + 2'd1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (abort) begin
        state_d       = IDLE;
        out_valid_d   = 1'b0;
        out_last_sc_d = 1'b0;
        out_last_d    = 1'b0;
        sc_cnt_d      = '0;
        sym_cnt_d     = '0;
        loaded_all_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      sc_cnt_q      <= '0;
      sym_cnt_q     <= '0;
      last_sym_q    <= '0;
      ss_q          <= '0;
      loaded_all_q  <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sym_q     <= '0;
      out_last_sc_q <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sc_cnt_q      <= sc_cnt_d;
      sym_cnt_q     <= sym_cnt_d;
      last_sym_q    <= last_sym_d;
      ss_q          <= ss_d;
      loaded_all_q  <= loaded_all_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_sym_q     <= out_sym_d;
      out_last_sc_q <= out_last_sc_d;
      out_last_q    <= out_last_d;
    end
  end

  assign rom_addr    = AW'(sc_cnt_q);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sym_idx = out_sym_q;
  assign out_last_sc = out_last_sc_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule
